aes_key_schedule_ctrl: RTL and testbench

// Sequencer and round-key store for the per-round key expansion stage.
// - Accepts a 128-bit cipher key over a valid/ready handshake.
// - Loads the key into the expansion stage, then steps it through 10 rounds by driving round/cnt.
// - Captures all 11 round keys into a local store; the cipher datapath reads them by index.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_round_key_store.sv | 40 ++++
 rtl/aes_key_schedule_ctrl.sv | 122 ++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule sequencer: sizes, FSM encoding
// and the step-counter values that carry meaning for the expansion stage.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_CAP0 = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Step on which the expansion stage is idle and its output is stable.
    localparam logic [2:0] KE_CNT_CAPTURE = 3'd6;
    // Parked value while no round is being stepped.
    localparam logic [2:0] KE_CNT_IDLE    = 3'd7;
    localparam logic [2:0] KE_CNT_FIRST   = 3'd0;

endpackage

// File: rtl/aes_round_key_store.sv
// Register file holding the NR+1 round keys. One write port, one registered
// read port; out-of-range reads return zero. Contents survive reset.
module aes_round_key_store
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [3:0]    widx,
    input  logic [KW-1:0] wdata,
    input  logic [3:0]    rd_idx,
    output logic [KW-1:0] rd_data
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    logic [KW-1:0] mem [0:NR];

    // Capture a round key; storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we && (widx <= LAST_IDX)) begin
            mem[widx] <= wdata;
        end
    end

    // Registered read; a read colliding with a write sees the previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_idx <= LAST_IDX) begin
            rd_data <= mem[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Sequencer for the per-round key expansion stage: accepts a cipher key,
// loads it into the expansion stage, steps it through NR rounds and captures
// every round key into a local store readable by the cipher datapath.
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [KW-1:0] key_in,
    output logic          ke_init_n,
    output logic [KW-1:0] ke_key,
    output logic [3:0]    ke_round,
    output logic [2:0]    ke_cnt,
    input  logic [KW-1:0] ke_round_key,
    output logic          busy,
    output logic          sched_done,
    input  logic [3:0]    rk_rd_idx,
    output logic [KW-1:0] rk_rd_data
);

    localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

    state_t     state;
    logic       store_we;
    logic [3:0] store_widx;

    // Store write strobe: key 0 right after the load, key r+1 on the idle step of round r.
    always_comb begin
        store_we   = 1'b0;
        store_widx = 4'd0;
        if (state == ST_CAP0) begin
            store_we   = 1'b1;
            store_widx = 4'd0;
        end else if ((state == ST_RUN) && (ke_cnt == KE_CNT_CAPTURE)) begin
            store_we   = 1'b1;
            store_widx = ke_round + 4'd1;
        end
    end

    // Schedule FSM with registered handshake, status and expansion-stage controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            key_ready  <= 1'b1;
            ke_init_n  <= 1'b1;
            ke_key     <= '0;
            ke_round   <= 4'd0;
            ke_cnt     <= KE_CNT_IDLE;
            busy       <= 1'b0;
            sched_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A new key restarts the schedule; old store entries stay until overwritten.
                    if (key_valid) begin
                        state      <= ST_INIT;
                        ke_key     <= key_in;
                        ke_init_n  <= 1'b0;
                        ke_round   <= 4'd0;
                        ke_cnt     <= KE_CNT_IDLE;
                        busy       <= 1'b1;
                        key_ready  <= 1'b0;
                        sched_done <= 1'b0;
                    end
                end
                ST_INIT: begin
                    // Expansion stage has taken the key during the low pulse.
                    state     <= ST_CAP0;
                    ke_init_n <= 1'b1;
                end
                ST_CAP0: begin
                    state  <= ST_RUN;
                    ke_cnt <= KE_CNT_FIRST;
                end
                ST_RUN: begin
                    if (ke_cnt == KE_CNT_CAPTURE) begin
                        if (ke_round == LAST_ROUND) begin
                            // Final key captured this cycle; round index is left as-is.
                            state      <= ST_DONE;
                            ke_cnt     <= KE_CNT_IDLE;
                            busy       <= 1'b0;
                            key_ready  <= 1'b1;
                            sched_done <= 1'b1;
                        end else begin
                            ke_round <= ke_round + 4'd1;
                            ke_cnt   <= KE_CNT_FIRST;
                        end
                    end else begin
                        ke_cnt <= ke_cnt + 3'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    key_ready  <= 1'b1;
                    ke_init_n  <= 1'b1;
                    ke_cnt     <= KE_CNT_IDLE;
                    busy       <= 1'b0;
                    sched_done <= 1'b0;
                end
            endcase
        end
    end

    aes_round_key_store #(
        .NR (NR),
        .KW (KW)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (store_we),
        .widx    (store_widx),
        .wdata   (ke_round_key),
        .rd_idx  (rk_rd_idx),
        .rd_data (rk_rd_data)
    );

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Bench for aes_key_schedule_ctrl: behavioural expansion stage, read-port
// scoreboard and directed scenarios (FIPS-197 key, ignored key, back-to-back,
// reset mid-schedule, out-of-range reads).
module tb_aes_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         ke_init_n;
    logic [127:0] ke_key;
    logic [3:0]   ke_round;
    logic [2:0]   ke_cnt;
    logic [127:0] ke_round_key;
    logic         busy;
    logic         sched_done;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int accept_edge = 0;
    logic [127:0] exp_q [$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B    = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] KEY_C    = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] KEY_D    = 128'h5a5a5a5a3c3c3c3c0f0f0f0fa5a5a5a5;

    logic [7:0] sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] rcon [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    // Cipher key (w0 in the top word) to round-key layout {w3,w2,w1,w0}.
    function automatic logic [127:0] to_rk(input logic [127:0] k);
        return {k[31:0], k[63:32], k[95:64], k[127:96]};
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] rk, input int r);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = rk[31:0]; w1 = rk[63:32]; w2 = rk[95:64]; w3 = rk[127:96];
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox[t[31:24]] ^ rcon[r], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input int idx);
        logic [127:0] rk;
        rk = to_rk(k);
        for (int i = 0; i < idx; i++) rk = next_rk(rk, i);
        return rk;
    endfunction

    // Behavioural expansion stage: loads while ke_init_n is low, advances on step 5.
    logic [127:0] stage_rk;
    always_ff @(posedge clk) begin
        if (!ke_init_n) stage_rk <= to_rk(ke_key);
        else if (ke_cnt == 3'd5) stage_rk <= next_rk(stage_rk, int'(ke_round));
    end
    assign ke_round_key = stage_rk;

    always_ff @(posedge clk) edge_cnt <= edge_cnt + 1;

    always #5 clk = ~clk;

    aes_key_schedule_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
        .ke_init_n    (ke_init_n),
        .ke_key       (ke_key),
        .ke_round     (ke_round),
        .ke_cnt       (ke_cnt),
        .ke_round_key (ke_round_key),
        .busy         (busy),
        .sched_done   (sched_done),
        .rk_rd_idx    (rk_rd_idx),
        .rk_rd_data   (rk_rd_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboarded read: expectation queued on drive, compared when data returns.
    task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
        rk_rd_idx = idx;
        exp_q.push_back(exp);
        @(negedge clk);
        check($sformatf("rd_idx%0d", idx), rk_rd_data, exp_q.pop_front());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"},  key_ready,  1);
        check({tag, "_ke_init_n"},  ke_init_n,  1);
        check({tag, "_ke_key"},     ke_key,     0);
        check({tag, "_ke_round"},   ke_round,   0);
        check({tag, "_ke_cnt"},     ke_cnt,     7);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_sched_done"}, sched_done, 0);
        check({tag, "_rd_data"},    rk_rd_data, 0);
    endtask

    task automatic accept_key(input logic [127:0] k);
        int w = 0;
        while (!key_ready && w < 200) begin @(negedge clk); w++; end
        check("accept_ready", key_ready, 1);
        key_in = k;
        key_valid = 1'b1;
        @(negedge clk);
        accept_edge = edge_cnt;
        key_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_done_low", sched_done, 0);
        check("accept_ke_key", ke_key, k);
        check("accept_init_n", ke_init_n, 0);
    endtask

    task automatic wait_done();
        int w = 0;
        while (!sched_done && w < 300) begin @(negedge clk); w++; end
        check("latency", edge_cnt - accept_edge, 72);
        check("done_key_ready", key_ready, 1);
        check("done_busy", busy, 0);
        check("done_ke_cnt", ke_cnt, 7);
        check("done_ke_round", ke_round, 9);
    endtask

    initial begin
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_in = '0;
        rk_rd_idx = 4'd0;
        cyc(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc(2);

        // FIPS-197 key: published round keys plus full comparison against the model.
        accept_key(FIPS_KEY);
        wait_done();
        rd(4'd0,  128'h09cf4f3c_abf71588_28aed2a6_2b7e1516);
        rd(4'd1,  128'h2a6c7605_23a33939_88542cb1_a0fafe17);
        rd(4'd10, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8);
        for (int i = 0; i <= 10; i++) rd(4'(i), expand(FIPS_KEY, i));

        // Key offered while busy is dropped.
        accept_key(KEY_A);
        cyc(20);
        check("busy_key_ready", key_ready, 0);
        key_in = KEY_B;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("busy_ke_key_kept", ke_key, KEY_A);
        check("busy_still_busy", busy, 1);
        wait_done();
        for (int i = 0; i <= 10; i++) rd(4'(i), expand(KEY_A, i));

        // Back-to-back: accepted in DONE, old idx10 visible until the last capture.
        accept_key(KEY_C);
        cyc(38);
        rd(4'd10, expand(KEY_A, 10));
        rd(4'd1,  expand(KEY_C, 1));
        wait_done();
        rd(4'd10, expand(KEY_C, 10));

        // Reset about 30 cycles into a schedule.
        accept_key(KEY_D);
        cyc(29);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        rd(4'd10, expand(KEY_C, 10));
        accept_key(FIPS_KEY);
        wait_done();
        rd(4'd10, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8);

        // Out-of-range read indices.
        for (int i = 11; i <= 15; i++) rd(4'(i), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
